sa2x2_job_sequencer: RTL
========================

# sa2x2_job_sequencer

Job sequencer for the 2x2 systolic array (`SystolicArray2x2`). It accepts whole 2x2 operand pairs (A, B) through a valid/ready request port. It drives the array's skewed weight/data injection schedule, with back-to-back jobs overlapped at the array's maximum rate of one job per 2 cycles. It captures the four accumulator outputs at the fixed result cycle and returns them in order through a buffered valid/ready response port.

## Interface
Parameters:
- `DATA_WIDTH`, 4: operand element width
- `ACC_WIDTH`, 9: result element width (must be ≥ 2·DATA_WIDTH+1)
- `RES_DEPTH`, 4: result FIFO entries; also the cap on jobs in flight plus buffered (min 1)

Ports:
- `clk` in 1: clock. One clock; reset is synchronous and active-high.
- `rst` in 1: synchronous reset, active-high
- `req_valid` in 1: request job present
- `req_ready` out 1: sequencer accepts job this cycle
- `req_a` in 4·DATA_WIDTH: {a11,a10,a01,a00}
- `req_b` in 4·DATA_WIDTH: {b11,b10,b01,b00}
- `sa_in_valid` out 1: to array `in_valid`
- `sa_a00`..`sa_a11`, `sa_b00`..`sa_b11` out DATA_WIDTH each: to array operand ports
- `sa_out_valid` in 1: from array
- `sa_c00`..`sa_c11` in ACC_WIDTH each: from array
- `rsp_valid` out 1: result available
- `rsp_ready` in 1: consumer takes result
- `rsp_c` out 4·ACC_WIDTH: {c11,c10,c01,c00}
- `busy` out 1: any job in stages 0..6 or FIFO non-empty
- `err` out 1: sticky out_valid mismatch (only with macro, else tied 0)

## Operation
- Handshake: job accepted when `req_valid && req_ready`. `req_ready = !stage0_valid && (inflight + fifo_count < RES_DEPTH)`. Valid/ready independent: ready never waits on valid.
- Accepted job enters stage 0 at the next edge. A 7-stage valid pipeline (stages 0..6) shifts every cycle, with no stalls. Operands travel in stages 0..4.
- Phase k means the job is in stage k. Drive schedule per phase:
  - 0: b01
  - 1: b00, b10
  - 2: b11, a00
  - 3: a01, a10
  - 4: a11
- Each operand port is the OR of the contributions of all valid stages; undriven ports are 0.
- Spacing ≥ 2 (guaranteed by ready rule) makes overlaps collision-free.
- `sa_in_valid` = any valid job in phases 2..5.
- Phase 6: sample `sa_c00..c11` and push `{c11,c10,c01,c00}` into the result FIFO. The credit rule guarantees the FIFO is never full at a push.
- `inflight` = count of valid stages 0..6. Increments on accept, decrements on push; both in the same cycle means no change.
- FIFO push and pop in the same cycle are both honoured. Pop when empty is ignored.
- `rsp_c` is the FIFO head. It is stable while `rsp_valid && !rsp_ready`.
- Reset mid-operation: all stage valids, the FIFO and `err` clear. Jobs in flight are dropped, no result is emitted, and all outputs take their reset values on the next cycle.

## Timing
- Reset values: `req_ready` 0 during rst, 1 on the first cycle after. `sa_in_valid` 0, all `sa_a*`/`sa_b*` 0, `rsp_valid` 0, `rsp_c` 0, `busy` 0, `err` 0.
- Accept at cycle t: phase 0 at t+1, first `sa_in_valid` at t+3, capture at t+7, `rsp_valid` at t+8 (FIFO registered output).
- Maximum throughput is one job per 2 cycles. With `req_valid` held high, accepts occur at t, t+2, t+4, …
- `RES_DEPTH` stalled results plus in-flight jobs block further accepts until a pop.

## Configuration
- `SA2X2_SEQ_OUTVALID_CHECK_EN` defined: at each phase-6 capture, `sa_out_valid` low sets `err` (sticky until rst). The capture still occurs.
- Not defined: `sa_out_valid` is ignored and `err` is tied 0.

## Structure
- Package `sa2x2_seq_pkg`:
  - `PH_LAST_OPND`=4, `PH_CAPTURE`=6, `MIN_SPACING`=2
  - packed operand type `sa_mat_t` and result type `sa_res_t` (parameterised by width function)
- Sub-module `sa2x2_seq_result_fifo`: synchronous FIFO, depth `RES_DEPTH`, registered head, count output.

## Test plan
- Single job, A={a00=5,a01=1,a10=13,a11=6}, B={b00=6,b01=10,b10=14,b11=9}, accepted at t:
  - t+1 drives b01=10; t+2 drives b00=6, b10=14; t+3 drives b11=9, a00=5; t+4 drives a01=1, a10=13; t+5 drives a11=6
  - `sa_in_valid` high t+3..t+6
  - `rsp_c` = {184,162,59,44} at t+8
- `req_valid` held high for 3 jobs: accepts exactly at t, t+2, t+4. No port carries two nonzero contributions. Three results are returned in order.
- `rsp_ready`=0 with 5 jobs offered (RES_DEPTH=4): `req_ready` stays low after the 4th accept. Raising `rsp_ready` for one cycle re-enables exactly one accept.
- rst pulsed at t+4 of an active job: `rsp_valid` never rises, all `sa_*` outputs are 0 at t+5, and `busy`=0.
- With the macro defined, force `sa_out_valid`=0 at the capture cycle: `err` goes to 1 next cycle and holds until rst. Without the macro, `err` stays 0.

Source files
------------

// File: rtl/sa2x2_seq_pkg.sv
// sa2x2_seq_pkg: shared phase constants, width helper and operand/result types for the 2x2 job sequencer
package sa2x2_seq_pkg;

    localparam int PH_LAST_OPND = 4;
    localparam int PH_CAPTURE   = 6;
    localparam int MIN_SPACING  = 2;

    localparam int SA_DW = 4;
    localparam int SA_AW = 9;

    function automatic int mat_w(input int w);
        return 4 * w;
    endfunction

    typedef logic [mat_w(SA_DW)-1:0] sa_mat_t;
    typedef logic [mat_w(SA_AW)-1:0] sa_res_t;

endpackage

// File: rtl/sa2x2_seq_result_fifo.sv
// sa2x2_seq_result_fifo: result FIFO with registered storage head and occupancy count
module sa2x2_seq_result_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 4,
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    assign push_ok  = push && count != CW'(DEPTH);
    assign pop_ok   = pop && count != '0;
    assign rd_valid = count != '0;
    assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

    // storage write; no reset needed because the head is masked while empty
    always_ff @(posedge clk)
        if (push_ok) mem[wr_ptr] <= push_data;

    // pointers and occupancy; simultaneous push and pop both take effect
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= nxt(wr_ptr);
            if (pop_ok) rd_ptr <= nxt(rd_ptr);
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

endmodule

// File: rtl/sa2x2_job_sequencer.sv
// sa2x2_job_sequencer: feeds skewed operands to a 2x2 systolic array and returns results in order
// optional macro SA2X2_SEQ_OUTVALID_CHECK_EN: flag a missing array out_valid at capture in err
module sa2x2_job_sequencer
    import sa2x2_seq_pkg::*;
#(
    parameter int DATA_WIDTH = 4,
    parameter int ACC_WIDTH  = 9,
    parameter int RES_DEPTH  = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [mat_w(DATA_WIDTH)-1:0]   req_a,
    input  logic [mat_w(DATA_WIDTH)-1:0]   req_b,
    output logic                           sa_in_valid,
    output logic [DATA_WIDTH-1:0]          sa_a00,
    output logic [DATA_WIDTH-1:0]          sa_a01,
    output logic [DATA_WIDTH-1:0]          sa_a10,
    output logic [DATA_WIDTH-1:0]          sa_a11,
    output logic [DATA_WIDTH-1:0]          sa_b00,
    output logic [DATA_WIDTH-1:0]          sa_b01,
    output logic [DATA_WIDTH-1:0]          sa_b10,
    output logic [DATA_WIDTH-1:0]          sa_b11,
    input  logic                           sa_out_valid,
    input  logic [ACC_WIDTH-1:0]           sa_c00,
    input  logic [ACC_WIDTH-1:0]           sa_c01,
    input  logic [ACC_WIDTH-1:0]           sa_c10,
    input  logic [ACC_WIDTH-1:0]           sa_c11,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [mat_w(ACC_WIDTH)-1:0]    rsp_c,
    output logic                           busy,
    output logic                           err
);

    localparam int DW = DATA_WIDTH;
    localparam int CW = $clog2(RES_DEPTH + 1);
    localparam int PH_LAST_B = 2;

    logic [PH_CAPTURE:0]          v;
    logic [mat_w(DW)-1:0]         a_s [PH_LAST_OPND+1];
    logic [mat_w(DW)-1:0]         b_s [PH_LAST_B+1];
    logic [CW-1:0]                fifo_count;
    logic                         accept;
    logic                         unused_opnd;

    // a stage-0 job blocks the next accept, giving the minimum spacing; credits cover in-flight plus buffered
    assign req_ready = !rst && !(|v[MIN_SPACING-2:0]) && ($countones(v) + int'(fifo_count) < RES_DEPTH);
    assign accept    = req_valid && req_ready;

    // stage valid pipeline; shifts every cycle with no stalls
    always_ff @(posedge clk) begin
        if (rst) v <= '0;
        else v <= {v[PH_CAPTURE-1:0], accept};
    end

    // operand pipeline; contents only matter where the matching stage valid is set
    always_ff @(posedge clk) begin
        a_s[0] <= req_a;
        b_s[0] <= req_b;
        for (int i = 1; i <= PH_LAST_OPND; i++) a_s[i] <= a_s[i-1];
        for (int i = 1; i <= PH_LAST_B; i++) b_s[i] <= b_s[i-1];
    end

    // each array port is fed by exactly one phase, so a gated slice is the whole OR
    assign sa_b01 = v[0] ? b_s[0][2*DW-1:DW]   : '0;
    assign sa_b00 = v[1] ? b_s[1][DW-1:0]      : '0;
    assign sa_b10 = v[1] ? b_s[1][3*DW-1:2*DW] : '0;
    assign sa_b11 = v[2] ? b_s[2][4*DW-1:3*DW] : '0;
    assign sa_a00 = v[2] ? a_s[2][DW-1:0]      : '0;
    assign sa_a01 = v[3] ? a_s[3][2*DW-1:DW]   : '0;
    assign sa_a10 = v[3] ? a_s[3][3*DW-1:2*DW] : '0;
    assign sa_a11 = v[4] ? a_s[4][4*DW-1:3*DW] : '0;

    assign sa_in_valid = |v[5:2];
    assign busy        = |v || fifo_count != '0;
    assign unused_opnd = ^{a_s[PH_LAST_OPND][3*DW-1:0], b_s[PH_LAST_B][3*DW-1:0]};

    sa2x2_seq_result_fifo #(
        .WIDTH (mat_w(ACC_WIDTH)),
        .DEPTH (RES_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (v[PH_CAPTURE]),
        .push_data ({sa_c11, sa_c10, sa_c01, sa_c00}),
        .pop       (rsp_ready),
        .rd_valid  (rsp_valid),
        .rd_data   (rsp_c),
        .count     (fifo_count)
    );

`ifdef SA2X2_SEQ_OUTVALID_CHECK_EN
    logic err_q;

    // sticky flag for a capture without the array asserting out_valid
    always_ff @(posedge clk) begin
        if (rst) err_q <= 1'b0;
        else if (v[PH_CAPTURE] && !sa_out_valid) err_q <= 1'b1;
    end

    assign err = err_q;
`else
    logic unused_out_valid;

    assign unused_out_valid = sa_out_valid;
    assign err = 1'b0;
`endif

endmodule
